controller_rx: RTL and testbench
================================

# controller_rx

USB full-speed receive-side packet controller, the counterpart to the transmit controller in the USB endpoint datapath. It consumes byte and line events from the RX front end (edge detector, EOP detector, 8-bit shift register with byte counter). It validates SYNC and PID, routes data payload bytes into the shared 64-byte packet FIFO, and reports the received packet type and any error to the protocol layer.

## Interface
Parameters:
- TIMEOUT_CYCLES, 800, clk cycles allowed between byte events mid-packet; used only when RX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- d_edge  in  1  one-cycle pulse on any D+/D- transition.
- eop  in  1  one-cycle pulse when an SE0 EOP is detected.
- byte_received  in  1  one-cycle pulse when rcv_data holds a complete byte.
- rcv_data  in  8  received byte; valid only while byte_received=1.
- buffer_occupancy  in  7  current FIFO fill, 0..64.
- rcving  out  1  high from the start of packet until the packet ends or reaches error hold.
- w_enable  out  1  FIFO write pulse.
- rx_byte  out  8  byte written to the FIFO; valid while w_enable=1.
- flush  out  1  one-cycle pulse that clears the FIFO when a DATA PID is accepted.
- rx_packet  out  3  last packet type: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL.
- rx_data_ready  out  1  one-cycle pulse when a DATA packet completes cleanly.
- rx_error  out  1  error status; held until the next packet starts.

## Operation
- States: IDLE, SYNC, PID, TOKEN1, TOKEN2, HS_EOP, DATA, EOP_WAIT, DONE, ERR_DRAIN, ERR_EOP, ERR_HOLD.
- IDLE: on d_edge go to SYNC.
- SYNC: on byte_received, go to PID if rcv_data==8'h80, otherwise go to ERR_DRAIN.
- PID: on byte_received, if rcv_data[7:4] != ~rcv_data[3:0] go to ERR_DRAIN. Otherwise decode and latch the pending type:
  - OUT 8'hE1 and IN 8'h69 go to TOKEN1.
  - DATA0 8'hC3 and DATA1 8'h4B pulse flush and go to DATA.
  - ACK 8'hD2, NAK 8'h5A and STALL 8'h1E go to HS_EOP.
  - Any other valid-complement PID goes to ERR_DRAIN.
- TOKEN1: on byte_received go to TOKEN2. TOKEN2: on byte_received go to HS_EOP. Token bytes are not written to the FIFO.
- HS_EOP: on eop go to EOP_WAIT. On byte_received go to ERR_DRAIN.
- DATA:
  - On byte_received with buffer_occupancy<64: register rx_byte, then pulse w_enable.
  - On byte_received with buffer_occupancy==64: no write, go to ERR_DRAIN.
  - On eop: go to EOP_WAIT.
- EOP_WAIT: on d_edge (line back to J) go to DONE.
- DONE: load rx_packet from the pending type, pulse rx_data_ready if the type is DATA0 or DATA1, then go to IDLE.
- eop in SYNC, PID, TOKEN1 or TOKEN2 goes to ERR_EOP.
- ERR_DRAIN: on eop go to ERR_EOP. ERR_EOP: on d_edge go to ERR_HOLD.
- ERR_HOLD: rx_error=1. On d_edge clear rx_error and go to SYNC.
- rcving=1 in SYNC, PID, TOKEN1, TOKEN2, HS_EOP, DATA, EOP_WAIT, ERR_DRAIN and ERR_EOP.
- rx_packet is not updated on error; it keeps its previous value.

## Timing
- Reset: state=IDLE; all outputs 0, including rx_packet=0 and rx_byte=8'h00.
- w_enable, rx_byte, flush, rx_data_ready, rx_packet and rx_error are registered.
- w_enable and rx_byte: 1 cycle after the byte_received that carries the byte.
- flush: 1 cycle after the PID byte_received.
- rx_packet and rx_data_ready: update 1 cycle after entering DONE, i.e. 2 cycles after the closing d_edge.
- rcving is decoded from the state register and tracks the state with no added delay.
- byte_received and eop in the same cycle in DATA: the byte is written and the state goes to EOP_WAIT.
- The same pair in HS_EOP, TOKEN1 or TOKEN2 is an error; eop takes priority, so the next state is ERR_EOP.
- rst mid-packet: immediate return to IDLE and all outputs cleared. FIFO contents are the FIFO's own concern.
- d_edge in every state other than IDLE, EOP_WAIT, ERR_EOP and ERR_HOLD is ignored.

## Configuration
- RX_TIMEOUT_EN defined:
  - In SYNC, PID, TOKEN1, TOKEN2, HS_EOP and DATA, a counter runs.
  - The counter clears on entry to those states and on every byte_received or eop.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to ERR_HOLD and rx_error is set on the next cycle.
- RX_TIMEOUT_EN undefined: no counter is instantiated and no timeout exists; a stalled packet waits indefinitely.

## Structure
- Shared package usb_pkg holds:
  - the rx_packet_t enum (codes 0-7);
  - the PID constants: SYNC 8'h80, OUT, IN, DATA0, DATA1, ACK, NAK, STALL;
  - FIFO_DEPTH=64.
- The state enum stays local to the module.
- One sub-module, rx_timeout_counter: parameterised up-counter with clear and rollover flag. It is instantiated only under RX_TIMEOUT_EN.

## Test plan
- SYNC 80, PID C3, bytes 11 22 33, eop, d_edge -> flush once; w_enable 3x with rx_byte 11, 22, 33; rx_packet=3; rx_data_ready pulses once; rx_error=0.
- SYNC 80, PID D2, eop, d_edge -> no w_enable; rx_packet=5.
- SYNC 80, PID C4 (bad complement), eop, d_edge -> rx_error=1 and held. Next d_edge clears rx_error.
- DATA1 packet with buffer_occupancy=64 at the first payload byte -> no w_enable; rx_error=1 after eop and d_edge; rx_packet unchanged.
- SYNC 80, PID E1, one token byte, then eop -> ERR_EOP, then d_edge -> rx_error=1.
- With RX_TIMEOUT_EN: SYNC, PID 4B, then silence for TIMEOUT_CYCLES -> rx_error=1 and rcving=0. Assert rst mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: received packet type codes, PID byte values and FIFO depth.
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_STALL = 3'd7
    } rx_packet_t;

    localparam logic [7:0] PID_SYNC  = 8'h80;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam int FIFO_DEPTH = 64;

    // Upper nibble must be the bitwise complement of the lower nibble.
    function automatic logic pid_check_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

    // Maps a PID byte to its packet type; unsupported PIDs map to PKT_NONE.
    function automatic rx_packet_t pid_decode(input logic [7:0] pid);
        case (pid)
            PID_OUT:   return PKT_OUT;
            PID_IN:    return PKT_IN;
            PID_DATA0: return PKT_DATA0;
            PID_DATA1: return PKT_DATA1;
            PID_ACK:   return PKT_ACK;
            PID_NAK:   return PKT_NAK;
            PID_STALL: return PKT_STALL;
            default:   return PKT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Up-counter with synchronous clear; rollover is high on the terminal count MAX_COUNT-1
// and the count wraps to zero on the following enabled cycle.
module rx_timeout_counter #(
    parameter int MAX_COUNT = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    localparam int W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;

    logic [W-1:0] count_reg;

    assign rollover = (count_reg == W'(MAX_COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= rollover ? '0 : count_reg + W'(1);
        end
    end

endmodule

// File: rtl/controller_rx.sv
// USB full-speed receive packet controller: checks SYNC/PID, routes DATA payload to the FIFO.
// Define RX_TIMEOUT_EN to abort packets whose byte stream stalls for TIMEOUT_CYCLES clocks.
module controller_rx
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic [6:0] buffer_occupancy,
    output logic       rcving,
    output logic       w_enable,
    output logic [7:0] rx_byte,
    output logic       flush,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_error
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SYNC      = 4'd1;
    localparam logic [3:0] S_PID       = 4'd2;
    localparam logic [3:0] S_TOKEN1    = 4'd3;
    localparam logic [3:0] S_TOKEN2    = 4'd4;
    localparam logic [3:0] S_HS_EOP    = 4'd5;
    localparam logic [3:0] S_DATA      = 4'd6;
    localparam logic [3:0] S_EOP_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR_DRAIN = 4'd9;
    localparam logic [3:0] S_ERR_EOP   = 4'd10;
    localparam logic [3:0] S_ERR_HOLD  = 4'd11;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [3:0] state_reg, state_next;
    rx_packet_t pending_reg, pending_next;
    rx_packet_t pid_type;
    rx_packet_t rx_packet_reg;
    logic       w_enable_reg, w_enable_next;
    logic [7:0] rx_byte_reg, rx_byte_next;
    logic       flush_reg, flush_next;
    logic       rx_data_ready_reg;
    logic       rx_error_reg;
    logic       fifo_full;
    logic       timed_state;
    logic       timeout_hit;

    assign pid_type    = pid_decode(rcv_data);
    assign fifo_full   = (buffer_occupancy >= 7'(FIFO_DEPTH));
    assign timed_state = state_reg inside {S_SYNC, S_PID, S_TOKEN1, S_TOKEN2, S_HS_EOP, S_DATA};

`ifdef RX_TIMEOUT_EN
    logic timer_clear;

    // Restart on every line event and whenever the state changes, so the budget is per gap.
    assign timer_clear = byte_received | eop | (state_next != state_reg) | ~timed_state;

    rx_timeout_counter #(
        .MAX_COUNT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timed_state),
        .rollover(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        w_enable_next = 1'b0;
        rx_byte_next  = rx_byte_reg;
        flush_next    = 1'b0;

        case (state_reg)
            S_IDLE: if (d_edge) state_next = S_SYNC;
            S_SYNC: begin
                if (eop)                state_next = S_ERR_EOP;
                else if (byte_received) state_next = (rcv_data == PID_SYNC) ? S_PID : S_ERR_DRAIN;
            end
            S_PID: begin
                if (eop) begin
                    state_next = S_ERR_EOP;
                end else if (byte_received) begin
                    state_next = S_ERR_DRAIN;
                    if (pid_check_ok(rcv_data)) begin
                        case (pid_type)
                            PKT_OUT, PKT_IN: begin
                                pending_next = pid_type;
                                state_next   = S_TOKEN1;
                            end
                            PKT_DATA0, PKT_DATA1: begin
                                pending_next = pid_type;
                                flush_next   = 1'b1;
                                state_next   = S_DATA;
                            end
                            PKT_ACK, PKT_NAK, PKT_STALL: begin
                                pending_next = pid_type;
                                state_next   = S_HS_EOP;
                            end
                            default: state_next = S_ERR_DRAIN;
                        endcase
                    end
                end
            end
            S_TOKEN1: begin
                if (eop)                state_next = S_ERR_EOP;
                else if (byte_received) state_next = S_TOKEN2;
            end
            S_TOKEN2: begin
                if (eop)                state_next = S_ERR_EOP;
                else if (byte_received) state_next = S_HS_EOP;
            end
            S_HS_EOP: begin
                if (eop)                state_next = byte_received ? S_ERR_EOP : S_EOP_WAIT;
                else if (byte_received) state_next = S_ERR_DRAIN;
            end
            S_DATA: begin
                if (byte_received) begin
                    if (!fifo_full) begin
                        w_enable_next = 1'b1;
                        rx_byte_next  = rcv_data;
                        state_next    = eop ? S_EOP_WAIT : S_DATA;
                    end else begin
                        // Overflow with the EOP already seen skips the drain wait.
                        state_next = eop ? S_ERR_EOP : S_ERR_DRAIN;
                    end
                end else if (eop) begin
                    state_next = S_EOP_WAIT;
                end
            end
            S_EOP_WAIT:  if (d_edge) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            S_ERR_DRAIN: if (eop) state_next = S_ERR_EOP;
            S_ERR_EOP:   if (d_edge) state_next = S_ERR_HOLD;
            S_ERR_HOLD:  if (d_edge) state_next = S_SYNC;
            default:     state_next = S_IDLE;
        endcase

        if (timed_state && timeout_hit && !byte_received && !eop) begin
            state_next = S_ERR_HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            pending_reg       <= PKT_NONE;
            rx_packet_reg     <= PKT_NONE;
            w_enable_reg      <= 1'b0;
            rx_byte_reg       <= 8'h00;
            flush_reg         <= 1'b0;
            rx_data_ready_reg <= 1'b0;
            rx_error_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pending_reg       <= pending_next;
            w_enable_reg      <= w_enable_next;
            rx_byte_reg       <= rx_byte_next;
            flush_reg         <= flush_next;
            rx_error_reg      <= (state_next == S_ERR_HOLD);
            rx_data_ready_reg <= (state_reg == S_DONE) &&
                                 (pending_reg == PKT_DATA0 || pending_reg == PKT_DATA1);
            if (state_reg == S_DONE) begin
                rx_packet_reg <= pending_reg;
            end
        end
    end

    assign rcving = state_reg inside {S_SYNC, S_PID, S_TOKEN1, S_TOKEN2, S_HS_EOP,
                                      S_DATA, S_EOP_WAIT, S_ERR_DRAIN, S_ERR_EOP};

    assign w_enable      = w_enable_reg;
    assign rx_byte       = rx_byte_reg;
    assign flush         = flush_reg;
    assign rx_packet     = rx_packet_reg;
    assign rx_data_ready = rx_data_ready_reg;
    assign rx_error      = rx_error_reg;

endmodule

// File: tb/tb_controller_rx.sv
// Scoreboard bench for controller_rx: packet-level reference model feeds expectation queues,
// a monitor pops them as FIFO writes, flushes and data-ready pulses appear.
module tb_controller_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       rcving;
    logic       w_enable;
    logic [7:0] rx_byte;
    logic       flush;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_error;

    controller_rx #(.TIMEOUT_CYCLES(40)) dut (
        .clk             (clk),
        .rst             (rst),
        .d_edge          (d_edge),
        .eop             (eop),
        .byte_received   (byte_received),
        .rcv_data        (rcv_data),
        .buffer_occupancy(buffer_occupancy),
        .rcving          (rcving),
        .w_enable        (w_enable),
        .rx_byte         (rx_byte),
        .flush           (flush),
        .rx_packet       (rx_packet),
        .rx_data_ready   (rx_data_ready),
        .rx_error        (rx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         exp_flush[$];
    logic [2:0] exp_ready[$];
    logic [2:0] last_pkt = 3'd0;
    logic [7:0] pl [0:3];
    logic [7:0] pid_tab [0:9] = '{8'hE1, 8'h69, 8'hC3, 8'h4B, 8'hD2,
                                  8'h5A, 8'h1E, 8'hC3, 8'h3C, 8'hC4};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    logic [7:0] mon_b;
    logic [2:0] mon_p;
    always @(negedge clk) begin
        if (!rst) begin
            if (w_enable) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL wr unexpected write rx_byte=%h", rx_byte);
                end else begin
                    mon_b = exp_bytes.pop_front();
                    if (rx_byte !== mon_b) begin
                        errors++;
                        $display("FAIL wr rx_byte got %h expected %h", rx_byte, mon_b);
                    end else $display("ok   wr rx_byte = %h", rx_byte);
                end
            end
            if (flush) begin
                checks++;
                if (exp_flush.size() == 0) begin
                    errors++;
                    $display("FAIL flush unexpected pulse got 1 expected 0");
                end else begin
                    void'(exp_flush.pop_front());
                    $display("ok   flush pulse");
                end
            end
            if (rx_data_ready) begin
                checks++;
                if (exp_ready.size() == 0) begin
                    errors++;
                    $display("FAIL ready unexpected pulse rx_packet=%0d", rx_packet);
                end else begin
                    mon_p = exp_ready.pop_front();
                    if (rx_packet !== mon_p) begin
                        errors++;
                        $display("FAIL ready rx_packet got %0d expected %0d", rx_packet, mon_p);
                    end else $display("ok   ready rx_packet = %0d", rx_packet);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_eop);
        rcv_data      = b;
        byte_received = 1'b1;
        eop           = with_eop;
        @(negedge clk);
        byte_received = 1'b0;
        eop           = 1'b0;
        rcv_data      = 8'($urandom);
        tick($urandom_range(0, 2));
    endtask

    function automatic logic [2:0] pid_code(input logic [7:0] pid);
        case (pid)
            8'hE1:   return 3'd1;
            8'h69:   return 3'd2;
            8'hC3:   return 3'd3;
            8'h4B:   return 3'd4;
            8'hD2:   return 3'd5;
            8'h5A:   return 3'd6;
            8'h1E:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Reference: a packet is clean when SYNC and PID are good, tokens carry exactly two
    // bytes before a separate EOP, handshakes carry none, and DATA never hits a full FIFO.
    task automatic send_packet(input logic [7:0] sync, input logic [7:0] pid, input int n,
                               input logic merge_in, input logic [6:0] occ);
        logic [2:0] code;
        logic       is_tok, is_data, is_hs, pid_ok, merge, err;
        code    = pid_code(pid);
        is_tok  = (code == 3'd1) || (code == 3'd2);
        is_data = (code == 3'd3) || (code == 3'd4);
        is_hs   = (code >= 3'd5);
        merge   = merge_in && (n > 0);
        pid_ok  = (sync == 8'h80) && (code != 3'd0);
        err     = !pid_ok || (is_tok && (n != 2 || merge)) || (is_hs && n != 0) ||
                  (is_data && occ == 7'd64 && n > 0);
        if (pid_ok && is_data) begin
            exp_flush.push_back(1);
            if (occ != 7'd64)
                for (int i = 0; i < n; i++) exp_bytes.push_back(pl[i]);
        end
        if (!err && is_data) exp_ready.push_back(code);

        buffer_occupancy = occ;
        pulse_edge();
        chk("start_rcving", {7'd0, rcving}, 8'd1);
        chk("start_err_clr", {7'd0, rx_error}, 8'd0);
        send_byte(sync, 1'b0);
        send_byte(pid, 1'b0);
        for (int i = 0; i < n; i++) send_byte(pl[i], merge && (i == n - 1));
        if (!merge) pulse_eop();
        tick(2);
        pulse_edge();
        tick(4);
        if (!err) last_pkt = code;
        $display("pkt sync=%h pid=%h n=%0d merge=%0d occ=%0d err=%0d", sync, pid, n, merge, occ, err);
        chk("end_rx_error", {7'd0, rx_error}, {7'd0, err});
        chk("end_rx_packet", {5'd0, rx_packet}, {5'd0, last_pkt});
        chk("end_rcving", {7'd0, rcving}, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s, p;
        tick(3);
        chk("rst_w_enable", {7'd0, w_enable}, 8'd0);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_rx_packet", {5'd0, rx_packet}, 8'd0);
        chk("rst_rx_error", {7'd0, rx_error}, 8'd0);
        chk("rst_rcving", {7'd0, rcving}, 8'd0);
        rst = 1'b0;
        tick(2);

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        send_packet(8'h80, 8'hC3, 3, 1'b0, 7'd10);
        send_packet(8'h80, 8'hD2, 0, 1'b0, 7'd0);
        send_packet(8'h80, 8'hC4, 0, 1'b0, 7'd0);
        tick(3);
        chk("err_held", {7'd0, rx_error}, 8'd1);
        send_packet(8'h80, 8'h4B, 2, 1'b0, 7'd64);
        send_packet(8'h80, 8'hE1, 1, 1'b0, 7'd0);
        send_packet(8'h80, 8'h69, 2, 1'b0, 7'd0);
        send_packet(8'h80, 8'h4B, 4, 1'b1, 7'd63);

        for (int k = 0; k < 40; k++) begin
            s = ($urandom_range(0, 9) == 0) ? 8'h81 : 8'h80;
            p = pid_tab[$urandom_range(0, 9)];
            for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
            send_packet(s, p, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 4) == 0) ? 7'd64 : 7'($urandom_range(0, 63)));
        end

`ifdef RX_TIMEOUT_EN
        pulse_edge();
        send_byte(8'h80, 1'b0);
        exp_flush.push_back(1);
        send_byte(8'h4B, 1'b0);
        tick(60);
        chk("timeout_rx_error", {7'd0, rx_error}, 8'd1);
        chk("timeout_rcving", {7'd0, rcving}, 8'd0);
        chk("timeout_rx_packet", {5'd0, rx_packet}, {5'd0, last_pkt});
`endif

        send_packet(8'h80, 8'h5A, 0, 1'b0, 7'd0);
        buffer_occupancy = 7'd5;
        pulse_edge();
        send_byte(8'h80, 1'b0);
        exp_flush.push_back(1);
        send_byte(8'hC3, 1'b0);
        exp_bytes.push_back(8'h55);
        send_byte(8'h55, 1'b0);
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rcving", {7'd0, rcving}, 8'd0);
        chk("midrst_rx_packet", {5'd0, rx_packet}, 8'd0);
        chk("midrst_rx_byte", rx_byte, 8'h00);
        chk("midrst_w_enable", {7'd0, w_enable}, 8'd0);
        chk("midrst_flush", {7'd0, flush}, 8'd0);
        chk("midrst_rx_error", {7'd0, rx_error}, 8'd0);
        chk("midrst_ready", {7'd0, rx_data_ready}, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        chk("left_bytes", 8'(exp_bytes.size()), 8'd0);
        chk("left_flush", 8'(exp_flush.size()), 8'd0);
        chk("left_ready", 8'(exp_ready.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
